// File: rtl/serial_word_capture_pkg.sv
// Shared types and helpers for the serial-to-parallel word capture block.
package serial_word_capture_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Width of the bit counter: ceil(log2(width)), never less than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_word_capture_bit_counter.sv
// Modulo-WIDTH up counter; tc flags the last bit position of a word.
module serial_word_capture_bit_counter
  import serial_word_capture_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc    = (count_q == CNT_W'(WIDTH - 1));
  assign count = count_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (en) count_d = tc ? '0 : count_q + CNT_W'(1);
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
  always_ff @(posedge clk) begin
    if (rst || clear) count_q <= '0;
    else              count_q <= count_d;
  end

endmodule

// File: rtl/serial_word_capture.sv
// Collects serial bits into a WIDTH-bit word and offers it over valid/ready.
module serial_word_capture
  import serial_word_capture_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int LSB_FIRST = 1,
  localparam int CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;
  logic             accept;
  logic             last_bit;

  // A held word can be handed off and a new bit taken in the same cycle.
  assign bit_ready = (state_q == COLLECT) || out_ready;
  assign accept    = bit_valid && bit_ready;

  serial_word_capture_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (accept),
    .count (bit_count),
    .tc    (last_bit)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    data_d    = data_q;
    overrun_d = overrun_q || (bit_valid && !bit_ready);

    if (accept) begin
      sreg_d = (LSB_FIRST != 0) ? {bit_in, sreg_q[WIDTH-1:1]}
                                : {sreg_q[WIDTH-2:0], bit_in};
    end

    case (state_q)
      COLLECT: begin
        if (accept && last_bit) begin
          data_d  = sreg_d;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q   <= COLLECT;
      sreg_q    <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign data_out  = data_q;
  assign overrun   = overrun_q;

endmodule
